demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Clocked 1-to-N demultiplexer, the inverse of the 2:1 select mux: one input stream is steered to one of N_OUT output channels by In_sel.
- Each output channel has a one-entry holding register with valid/ready handshake, so a stalled channel never corrupts another.
- Sits downstream of a shared producer; fans its traffic out to per-destination consumers.

Parameters:
- WIDTH, 8, data bits per word.
- N_OUT, 4, number of output channels (2..16).
- SEL_W, $clog2(N_OUT), derived select width; not overridden.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Rst_n  input  1  synchronous reset, active-low.
- In_data  input  WIDTH  input word.
- In_sel  input  SEL_W  destination channel index.
- In_valid  input  1  In_data/In_sel valid.
- In_ready  output  1  block accepts the word this cycle.
- Out_data  output  N_OUT*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- Out_valid  output  N_OUT  per-channel holding register full.
- Out_ready  input  N_OUT  per-channel consumer ready.
- Drop_cnt  output  8  count of words accepted with out-of-range In_sel; saturates at 255.
- Busy  output  1  OR of Out_valid.

Behaviour:
- Reset:
  - Sampled on Clk rising edge while Rst_n=0.
  - Out_valid=0, Out_data=0, Drop_cnt=0, Busy=0.
  - Reset mid-transfer discards held words; no handshake completes that cycle.
- Ready:
  - In_ready is combinational from In_sel, Out_valid and Out_ready.
  - If In_sel < N_OUT: In_ready = !Out_valid[In_sel] | Out_ready[In_sel].
  - If In_sel >= N_OUT: In_ready = 1.
  - In_ready never depends on In_valid.
- Accept: transfer when In_valid & In_ready on a rising edge.
  - Valid select: In_data is loaded into channel In_sel's register and Out_valid[In_sel] = 1 next cycle (latency 1).
  - Out-of-range select (only possible when N_OUT is not a power of 2): word is discarded and Drop_cnt increments by 1, holding at 255.
- Output handshake:
  - Channel i drains when Out_valid[i] & Out_ready[i].
  - On drain with no refill, Out_valid[i] goes to 0 next cycle; Out_data[i] keeps its last value (don't-care).
  - While Out_valid[i]=1 and Out_ready[i]=0, Out_data[i] is held stable.
- Simultaneous drain and fill of the same channel: new word loads, Out_valid stays 1, giving full throughput of 1 word/cycle per channel.
- Channels are independent:
  - A stall on channel j blocks only inputs addressed to j.
  - Per-channel order is preserved; no cross-channel ordering guarantee beyond arrival order.
- Per-channel state machine: EMPTY -(accept)-> FULL; FULL -(drain & !accept)-> EMPTY; FULL -(drain & accept)-> FULL; FULL -(!drain)-> FULL.
- Out_data, Out_valid and Drop_cnt are fully registered. In_ready is the only combinational output.
- Out_ready asserted on an EMPTY channel has no effect.

Test Plan:
- Reset: drive Rst_n=0 for 2 cycles with In_valid=1, then release → Out_valid=0000, Drop_cnt=0, Busy=0. The first accept happens only after release.
- Basic route (N_OUT=4): In_sel=2, In_data=0xA5, In_valid=1 for one cycle, Out_ready=0 → next cycle Out_valid=0100, Out_data[23:16]=0xA5, Busy=1. The word is held for 5 cycles, then Out_ready[2]=1 drains it; Out_valid=0000 the cycle after.
- Backpressure: fill ch1 with 0x11 and hold Out_ready[1]=0, then present In_sel=1, 0x22 → In_ready=0 and 0x22 stays pending. Present In_sel=3, 0x33 → accepted, ch3=0x33. Release Out_ready[1] → 0x11 drains, then 0x22 loads.
- Streaming: Out_ready=1111, send 0x00..0x0F to ch0 on consecutive cycles → In_ready stays 1, Out_valid[0] stays 1, and ch0 outputs 0x00..0x0F in order, one per cycle.
- Drop (N_OUT=3, SEL_W=2): send 300 words with In_sel=3 → In_ready=1 throughout, Out_valid=000 throughout, Drop_cnt=255 (saturated).
- Reset mid-operation: hold ch0=0x5A and ch1=0x6B (Out_ready=0), pulse Rst_n=0 for one cycle → Out_valid=0000 and Drop_cnt=0 the next cycle; neither word is ever delivered.

Source files
------------

// File: rtl/demux_router_if.sv
// Handshake bundle for demux_router: one producer-side input stream and
// N_OUT consumer-side channels packed into flat vectors.
interface demux_router_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) ();
  localparam int SEL_W = $clog2(N_OUT);

  logic [WIDTH-1:0]       In_data;
  logic [SEL_W-1:0]       In_sel;
  logic                   In_valid;
  logic                   In_ready;
  logic [N_OUT*WIDTH-1:0] Out_data;
  logic [N_OUT-1:0]       Out_valid;
  logic [N_OUT-1:0]       Out_ready;
  logic [7:0]             Drop_cnt;
  logic                   Busy;

  // Producer/consumer side (drives the router's inputs)
  modport master (
    output In_data, In_sel, In_valid, Out_ready,
    input  In_ready, Out_data, Out_valid, Drop_cnt, Busy
  );

  // Router side
  modport slave (
    input  In_data, In_sel, In_valid, Out_ready,
    output In_ready, Out_data, Out_valid, Drop_cnt, Busy
  );
endinterface

// File: rtl/demux_router.sv
// Clocked 1-to-N demultiplexer. Each output channel owns a one-entry holding
// register with a valid/ready handshake; a stalled channel only backpressures
// words addressed to it. Words with an out-of-range select are dropped and
// counted (saturating at 255).
module demux_router #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) (
  input logic            Clk,
  input logic            Rst_n,
  demux_router_if.slave  bus
);
  localparam int SEL_W = $clog2(N_OUT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e              state_q [N_OUT];
  ch_state_e              state_d [N_OUT];
  logic [N_OUT*WIDTH-1:0] data_q;
  logic [N_OUT*WIDTH-1:0] data_d;
  logic [7:0]             drop_q;
  logic [7:0]             drop_d;
  logic                   busy_q;
  logic                   busy_d;

  logic [N_OUT-1:0]       hit_s;
  logic [N_OUT-1:0]       drain_s;
  logic [N_OUT-1:0]       valid_d_s;
  logic                   in_range_s;
  logic                   ready_s;
  logic                   accept_s;

  // Select decode, input-ready and per-channel next state / next data
  always_comb begin
    ready_s    = 1'b1;
    hit_s      = '0;
    drain_s    = '0;
    valid_d_s  = '0;
    data_d     = data_q;
    drop_d     = drop_q;
    for (int i = 0; i < N_OUT; i++) begin
      state_d[i] = state_q[i];
      drain_s[i] = (state_q[i] == FULL) && bus.Out_ready[i];
      if (bus.In_sel == SEL_W'(i)) begin
        hit_s[i] = 1'b1;
        ready_s  = (state_q[i] == EMPTY) || bus.Out_ready[i];
      end else begin
        hit_s[i] = 1'b0;
      end
    end
    in_range_s = |hit_s;
    accept_s   = bus.In_valid && ready_s;

    for (int i = 0; i < N_OUT; i++) begin
      case (state_q[i])
        EMPTY: begin
          if (accept_s && hit_s[i]) begin
            state_d[i]                = FULL;
            data_d[i*WIDTH +: WIDTH]  = bus.In_data;
          end else begin
            state_d[i] = EMPTY;
          end
        end
        FULL: begin
          if (accept_s && hit_s[i]) begin
            // drain and refill in the same cycle keeps full throughput
            state_d[i]                = FULL;
            data_d[i*WIDTH +: WIDTH]  = bus.In_data;
          end else if (drain_s[i]) begin
            state_d[i] = EMPTY;
          end else begin
            state_d[i] = FULL;
          end
        end
        default: begin
          state_d[i] = EMPTY;
        end
      endcase
      valid_d_s[i] = (state_d[i] == FULL);
    end

    if (accept_s && !in_range_s) begin
      if (drop_q == 8'd255) begin
        drop_d = drop_q;
      end else begin
        drop_d = drop_q + 8'd1;
      end
    end else begin
      drop_d = drop_q;
    end
    busy_d = |valid_d_s;
  end

  // Channel state, holding registers and drop counter with synchronous reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        state_q[i] <= EMPTY;
      end
      data_q <= '0;
      drop_q <= 8'd0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        state_q[i] <= state_d[i];
      end
      data_q <= data_d;
      drop_q <= drop_d;
      busy_q <= busy_d;
    end
  end

  // Output mapping: everything but In_ready comes straight from flops
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      bus.Out_valid[i] = (state_q[i] == FULL);
    end
    bus.In_ready = ready_s;
    bus.Out_data = data_q;
    bus.Drop_cnt = drop_q;
    bus.Busy     = busy_q;
  end
endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: a 4-channel instance for routing,
// backpressure, streaming and reset, and a 3-channel instance for drops.
module tb_demux_router;
  logic Clk;
  logic Rst_n;
  int   n_checks;
  int   n_pass;

  demux_router_if #(.WIDTH(8), .N_OUT(4)) if4 ();
  demux_router_if #(.WIDTH(8), .N_OUT(3)) if3 ();

  demux_router #(.WIDTH(8), .N_OUT(4)) u4 (.Clk(Clk), .Rst_n(Rst_n), .bus(if4));
  demux_router #(.WIDTH(8), .N_OUT(3)) u3 (.Clk(Clk), .Rst_n(Rst_n), .bus(if3));

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Directed stimulus and checks
  initial begin
    logic ok_ready;
    logic ok_valid;
    logic ok_order;
    n_checks = 0;
    n_pass   = 0;

    // reset with valid input pending
    Rst_n = 1'b0;
    if4.In_valid = 1'b1; if4.In_sel = 2'd0; if4.In_data = 8'h77; if4.Out_ready = 4'b0000;
    if3.In_valid = 1'b0; if3.In_sel = 2'd0; if3.In_data = 8'h00; if3.Out_ready = 3'b000;
    step(); step();
    check_val("rst_valid", 32'(if4.Out_valid), 32'h0);
    check_val("rst_drop", 32'(if4.Drop_cnt), 32'h0);
    check_val("rst_busy", 32'(if4.Busy), 32'h0);
    Rst_n = 1'b1;
    if4.In_valid = 1'b0;
    step();
    check_val("post_rst_valid", 32'(if4.Out_valid), 32'h0);

    // basic route to channel 2, held for 5 cycles, then drained
    if4.In_sel = 2'd2; if4.In_data = 8'hA5; if4.In_valid = 1'b1;
    #1 check_val("route_ready", 32'(if4.In_ready), 32'h1);
    step();
    if4.In_valid = 1'b0;
    check_val("route_valid", 32'(if4.Out_valid), 32'h4);
    check_val("route_data", 32'(if4.Out_data[23:16]), 32'hA5);
    check_val("route_busy", 32'(if4.Busy), 32'h1);
    ok_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (if4.Out_valid !== 4'b0100 || if4.Out_data[23:16] !== 8'hA5) ok_valid = 1'b0;
    end
    check_val("route_hold", 32'(ok_valid), 32'h1);
    if4.Out_ready = 4'b0100;
    step();
    if4.Out_ready = 4'b0000;
    check_val("drain_valid", 32'(if4.Out_valid), 32'h0);
    check_val("drain_busy", 32'(if4.Busy), 32'h0);

    // backpressure on channel 1 does not block channel 3
    if4.In_sel = 2'd1; if4.In_data = 8'h11; if4.In_valid = 1'b1;
    step();
    if4.In_data = 8'h22;
    #1 check_val("bp_ready_ch1", 32'(if4.In_ready), 32'h0);
    step();
    check_val("bp_hold_ch1", 32'(if4.Out_data[15:8]), 32'h11);
    check_val("bp_valid", 32'(if4.Out_valid), 32'h2);
    if4.In_sel = 2'd3; if4.In_data = 8'h33;
    #1 check_val("bp_ready_ch3", 32'(if4.In_ready), 32'h1);
    step();
    check_val("bp_valid_13", 32'(if4.Out_valid), 32'hA);
    check_val("bp_data_ch3", 32'(if4.Out_data[31:24]), 32'h33);
    if4.In_sel = 2'd1; if4.In_data = 8'h22; if4.Out_ready = 4'b0010;
    #1 check_val("bp_release_ready", 32'(if4.In_ready), 32'h1);
    check_val("bp_drain_word", 32'(if4.Out_data[15:8]), 32'h11);
    step();
    if4.In_valid = 1'b0; if4.Out_ready = 4'b0000;
    check_val("bp_refill_valid", 32'(if4.Out_valid), 32'hA);
    check_val("bp_refill_data", 32'(if4.Out_data[15:8]), 32'h22);
    if4.Out_ready = 4'b1111;
    step();
    check_val("bp_all_drained", 32'(if4.Out_valid), 32'h0);

    // streaming 0x00..0x0F into channel 0 at one word per cycle
    if4.In_sel = 2'd0; if4.In_valid = 1'b1;
    ok_ready = 1'b1; ok_valid = 1'b1; ok_order = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if4.In_data = 8'(k);
      #1 if (if4.In_ready !== 1'b1) ok_ready = 1'b0;
      step();
      if (if4.Out_valid[0] !== 1'b1) ok_valid = 1'b0;
      if (if4.Out_data[7:0] !== 8'(k)) ok_order = 1'b0;
    end
    if4.In_valid = 1'b0;
    check_val("stream_ready", 32'(ok_ready), 32'h1);
    check_val("stream_valid", 32'(ok_valid), 32'h1);
    check_val("stream_order", 32'(ok_order), 32'h1);
    step();
    check_val("stream_done", 32'(if4.Out_valid), 32'h0);
    if4.Out_ready = 4'b0000;

    // 3-channel instance: in-range route then 300 out-of-range drops
    if3.In_sel = 2'd2; if3.In_data = 8'h3C; if3.In_valid = 1'b1;
    step();
    if3.In_valid = 1'b0;
    check_val("n3_route_valid", 32'(if3.Out_valid), 32'h4);
    check_val("n3_route_data", 32'(if3.Out_data[23:16]), 32'h3C);
    if3.Out_ready = 3'b111;
    step();
    if3.Out_ready = 3'b000;
    if3.In_sel = 2'd3; if3.In_valid = 1'b1;
    ok_ready = 1'b1; ok_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      if3.In_data = 8'(k);
      #1 if (if3.In_ready !== 1'b1) ok_ready = 1'b0;
      step();
      if (if3.Out_valid !== 3'b000) ok_valid = 1'b0;
      if (k == 10) check_val("drop_cnt_10", 32'(if3.Drop_cnt), 32'd10);
    end
    if3.In_valid = 1'b0;
    check_val("drop_ready", 32'(ok_ready), 32'h1);
    check_val("drop_no_valid", 32'(ok_valid), 32'h1);
    check_val("drop_saturated", 32'(if3.Drop_cnt), 32'd255);
    check_val("drop_busy", 32'(if3.Busy), 32'h0);

    // reset while two channels hold words
    if4.In_sel = 2'd0; if4.In_data = 8'h5A; if4.In_valid = 1'b1;
    step();
    if4.In_sel = 2'd1; if4.In_data = 8'h6B;
    step();
    if4.In_valid = 1'b0;
    check_val("mid_loaded", 32'(if4.Out_valid), 32'h3);
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    check_val("mid_rst_valid", 32'(if4.Out_valid), 32'h0);
    check_val("mid_rst_data", 32'(if4.Out_data), 32'h0);
    check_val("mid_rst_drop", 32'(if3.Drop_cnt), 32'h0);
    check_val("mid_rst_busy", 32'(if4.Busy), 32'h0);
    if4.Out_ready = 4'b1111;
    ok_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (if4.Out_valid !== 4'b0000) ok_valid = 1'b0;
    end
    check_val("mid_never_delivered", 32'(ok_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
